// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared state encoding, widths and burst legality helper for the L2 request arbiter
package l2_pkg;

  localparam int LINE_WORDS = 16;
  localparam int BURST_W    = 5;
  localparam int TAG_W      = 21;
  localparam int SET_W      = 5;
  localparam int WORD_W     = 4;
  localparam int OFF_W      = 2;
  localparam int ADDR_W     = TAG_W + SET_W + WORD_W + OFF_W;
  localparam int DATA_W     = 32;
  localparam int WBUF_DEPTH = 16;
  localparam int WBUF_AW    = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WFILL     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_XFER      = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Rejects empty, oversized and line-crossing bursts.
  function automatic logic burst_ok(input logic [WORD_W-1:0] word,
                                    input logic [BURST_W-1:0] burst,
                                    input int line_words);
    logic [BURST_W:0] end_word;
    end_word = {{(BURST_W + 1 - WORD_W){1'b0}}, word} + {1'b0, burst};
    return (burst != '0) && (int'(burst) <= line_words) && (int'(end_word) <= line_words);
  endfunction

endpackage

// File: rtl/l2_req_arbiter_if.sv
// rtl/l2_req_arbiter_if.sv - requester and cache-group signals around the L2 request arbiter
interface l2_req_arbiter_if;
  import l2_pkg::*;

  logic                m0_req, m0_we, m0_wvalid;
  logic [ADDR_W-1:0]   m0_addr;
  logic [BURST_W-1:0]  m0_burst;
  logic [DATA_W-1:0]   m0_wdata;
  logic                m0_gnt, m0_rvalid, m0_done, m0_err;
  logic [DATA_W-1:0]   m0_rdata;

  logic                m1_req, m1_we, m1_wvalid;
  logic [ADDR_W-1:0]   m1_addr;
  logic [BURST_W-1:0]  m1_burst;
  logic [DATA_W-1:0]   m1_wdata;
  logic                m1_gnt, m1_rvalid, m1_done, m1_err;
  logic [DATA_W-1:0]   m1_rdata;

  logic                ds_rreq, ds_wreq, ds_wnext, ds_rvalid, ds_busy;
  logic [ADDR_W-1:0]   ds_addr;
  logic [BURST_W-1:0]  ds_burst;
  logic [DATA_W-1:0]   ds_wdata, ds_rdata;

  // master: the arbiter; slave: the requesters plus the cache group
  modport master (
    input  m0_req, m0_we, m0_addr, m0_burst, m0_wvalid, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_burst, m1_wvalid, m1_wdata,
    input  ds_wnext, ds_rdata, ds_rvalid, ds_busy,
    output m0_gnt, m0_rvalid, m0_rdata, m0_done, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_done, m1_err,
    output ds_rreq, ds_wreq, ds_addr, ds_burst, ds_wdata
  );

  modport slave (
    output m0_req, m0_we, m0_addr, m0_burst, m0_wvalid, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_burst, m1_wvalid, m1_wdata,
    output ds_wnext, ds_rdata, ds_rvalid, ds_busy,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_done, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_done, m1_err,
    input  ds_rreq, ds_wreq, ds_addr, ds_burst, ds_wdata
  );

endinterface

// File: rtl/l2_wbuf.sv
// rtl/l2_wbuf.sv - 16x32 write buffer with wrapping pointers and an occupancy count
module l2_wbuf
  import l2_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic [WBUF_AW:0]  count
);

  logic [DATA_W-1:0]  mem [WBUF_DEPTH];
  logic [WBUF_AW-1:0] wptr, rptr;
  logic [WBUF_AW:0]   cnt;
  logic               do_push, do_pop;

  assign do_push = push && (cnt != (WBUF_AW + 1)'(WBUF_DEPTH));
  assign do_pop  = pop && (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + WBUF_AW'(1);
      if (do_pop)  rptr <= rptr + WBUF_AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (WBUF_AW + 1)'(1);
        2'b01:   cnt <= cnt - (WBUF_AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/l2_req_arbiter.sv
// rtl/l2_req_arbiter.sv - two-port round-robin burst arbiter in front of an L2 cache group
module l2_req_arbiter #(
  parameter int LINE_WORDS = l2_pkg::LINE_WORDS,
  parameter int TIMEOUT    = 255
) (
  input logic              clk,
  input logic              reset,
  l2_req_arbiter_if.master bus
);
  import l2_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t              state;
  logic                last, port, we;
  logic [ADDR_W-1:0]   addr_q;
  logic [BURST_W-1:0]  burst, bcnt;
  logic [TW-1:0]       tcnt;
  logic [1:0]          gnt_q, done_q, err_q, port_sel;
  logic                rreq_q, wreq_q;

  logic                any_req, win, win_we, win_ok;
  logic [ADDR_W-1:0]   win_addr;
  logic [BURST_W-1:0]  win_burst;

  logic                in_xfer, rd_beat, wr_beat, push;
  logic [DATA_W-1:0]   push_data, wb_head;
  logic                wb_empty;
  logic [WBUF_AW:0]    wb_count;

  assign any_req   = bus.m0_req | bus.m1_req;
  // Simultaneous requests go to the port that did not win last time.
  assign win       = (bus.m0_req && bus.m1_req) ? ~last : bus.m1_req;
  assign win_we    = win ? bus.m1_we    : bus.m0_we;
  assign win_addr  = win ? bus.m1_addr  : bus.m0_addr;
  assign win_burst = win ? bus.m1_burst : bus.m0_burst;
  assign win_ok    = burst_ok(win_addr[OFF_W +: WORD_W], win_burst, LINE_WORDS);
  assign port_sel  = port ? 2'b10 : 2'b01;

  // Beats beyond the latched length are ignored.
  assign in_xfer   = (state == ST_XFER) && (bcnt < burst);
  assign rd_beat   = in_xfer && !we && bus.ds_rvalid;
  assign wr_beat   = in_xfer && we && bus.ds_wnext && !wb_empty;
  assign push      = (state == ST_WFILL) && (port ? bus.m1_wvalid : bus.m0_wvalid);
  assign push_data = port ? bus.m1_wdata : bus.m0_wdata;

  l2_wbuf u_wbuf (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_IDLE),
    .push  (push),
    .wdata (push_data),
    .pop   (wr_beat),
    .rdata (wb_head),
    .empty (wb_empty),
    .count (wb_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      last   <= 1'b1;
      port   <= 1'b0;
      we     <= 1'b0;
      addr_q <= '0;
      burst  <= '0;
      bcnt   <= '0;
      tcnt   <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      rreq_q <= 1'b0;
      wreq_q <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      rreq_q <= 1'b0;
      wreq_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt_q  <= win ? 2'b10 : 2'b01;
            last   <= win;
            port   <= win;
            we     <= win_we;
            addr_q <= win_addr & ~ADDR_W'(3);
            burst  <= win_burst;
            if (!win_ok) begin
              err_q <= win ? 2'b10 : 2'b01;
              state <= ST_DONE;
            end else begin
              state <= win_we ? ST_WFILL : ST_ISSUE;
            end
          end
        end
        ST_WFILL: begin
          if (push && ((wb_count + (WBUF_AW + 1)'(1)) == burst)) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!bus.ds_busy) begin
            rreq_q <= ~we;
            wreq_q <= we;
            tcnt   <= '0;
            state  <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (bus.ds_busy) begin
            bcnt  <= '0;
            state <= ST_XFER;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            err_q <= port_sel;
            state <= ST_DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_XFER: begin
          if (rd_beat || wr_beat) bcnt <= bcnt + BURST_W'(1);
          if ((bcnt == burst) && !bus.ds_busy) begin
            done_q <= port_sel;
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m0_done   = done_q[0];
  assign bus.m1_done   = done_q[1];
  assign bus.m0_err    = err_q[0];
  assign bus.m1_err    = err_q[1];
  assign bus.m0_rvalid = rd_beat && !port;
  assign bus.m1_rvalid = rd_beat && port;
  assign bus.m0_rdata  = (rd_beat && !port) ? bus.ds_rdata : '0;
  assign bus.m1_rdata  = (rd_beat && port)  ? bus.ds_rdata : '0;
  assign bus.ds_rreq   = rreq_q;
  assign bus.ds_wreq   = wreq_q;
  assign bus.ds_addr   = addr_q;
  assign bus.ds_burst  = burst;
  assign bus.ds_wdata  = ((state == ST_XFER) && we && !wb_empty) ? wb_head : '0;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb/tb_l2_req_arbiter.sv - directed checks for the L2 request arbiter
module tb_l2_req_arbiter;

  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  l2_req_arbiter_if bus();

  l2_req_arbiter #(.LINE_WORDS(16), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int n_rreq = 0, n_wreq = 0, n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0;

  always @(posedge clk) begin
    if (bus.ds_rreq === 1'b1) n_rreq += 1;
    if (bus.ds_wreq === 1'b1) n_wreq += 1;
    if (bus.m0_done === 1'b1) n_done0 += 1;
    if (bus.m1_done === 1'b1) n_done1 += 1;
    if (bus.m0_err === 1'b1) n_err0 += 1;
    if (bus.m1_err === 1'b1) n_err1 += 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int id);
    case (id)
      0: return bus.m0_gnt;
      1: return bus.m1_gnt;
      2: return bus.m0_done;
      3: return bus.m1_done;
      4: return bus.m0_err;
      5: return bus.m1_err;
      6: return bus.ds_rreq;
      7: return bus.ds_wreq;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_hi(input string tag, input int id, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sig(id) !== 1'b1) && (n < budget));
    chk(tag, 32'(sig(id)), 32'd1);
  endtask

  task automatic idle_inputs();
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_burst = '0; bus.m0_wvalid = 0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_burst = '0; bus.m1_wvalid = 0; bus.m1_wdata = '0;
    bus.ds_wnext = 0; bus.ds_rdata = '0; bus.ds_rvalid = 0; bus.ds_busy = 0;
  endtask

  task automatic serve_read(input int beats, input logic [31:0] base);
    wait_hi("srv_rreq", 6, 6);
    bus.ds_busy = 1;
    for (int i = 0; i < beats; i++) begin
      @(negedge clk);
      bus.ds_rvalid = 1;
      bus.ds_rdata = base + 32'(i);
    end
    @(negedge clk);
    bus.ds_rvalid = 0;
    bus.ds_busy = 0;
  endtask

  logic [31:0] wexp [3] = '{32'h11, 32'h22, 32'h33};

  initial begin
    idle_inputs();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), 32'd0);
    chk("rst_done_err", 32'({bus.m1_err, bus.m0_err, bus.m1_done, bus.m0_done}), 32'd0);
    chk("rst_ds_req", 32'({bus.ds_rreq, bus.ds_wreq}), 32'd0);
    chk("rst_ds_addr", bus.ds_addr, 32'd0);
    chk("rst_ds_burst", 32'(bus.ds_burst), 32'd0);
    chk("rst_ds_wdata", bus.ds_wdata, 32'd0);

    // read burst on port 0
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h0000_1040; bus.m0_burst = 5'd4;
    wait_hi("rd_gnt", 0, 4);
    chk("rd_gnt_other", 32'(bus.m1_gnt), 32'd0);
    bus.m0_req = 0;
    wait_hi("rd_rreq", 6, 4);
    chk("rd_ds_addr", bus.ds_addr, 32'h0000_1040);
    chk("rd_ds_burst", 32'(bus.ds_burst), 32'd4);
    chk("rd_no_wreq", 32'(bus.ds_wreq), 32'd0);
    bus.ds_busy = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ds_rvalid = 1;
      bus.ds_rdata = 32'hA0 + 32'(i);
      #1;
      chk("rd_rvalid", 32'(bus.m0_rvalid), 32'd1);
      chk("rd_rdata", bus.m0_rdata, 32'hA0 + 32'(i));
      chk("rd_other_rvalid", 32'(bus.m1_rvalid), 32'd0);
    end
    @(negedge clk);
    bus.ds_rdata = 32'hEE;
    #1;
    chk("rd_extra_rvalid", 32'(bus.m0_rvalid), 32'd0);
    chk("rd_extra_rdata", bus.m0_rdata, 32'd0);
    bus.ds_rvalid = 0;
    bus.ds_busy = 0;
    wait_hi("rd_done", 2, 4);
    @(negedge clk);
    chk("rd_done_pulse", 32'(bus.m0_done), 32'd0);
    chk("rd_done_count", 32'(n_done0), 32'd1);

    // write burst on port 1
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h0000_2000; bus.m1_burst = 5'd3;
    wait_hi("wr_gnt", 1, 4);
    chk("wr_gnt_other", 32'(bus.m0_gnt), 32'd0);
    bus.m1_req = 0;
    bus.m1_wvalid = 1; bus.m1_wdata = 32'h11;
    @(negedge clk);
    chk("wr_early_wreq1", 32'(bus.ds_wreq), 32'd0);
    bus.m1_wdata = 32'h22;
    @(negedge clk);
    chk("wr_early_wreq2", 32'(bus.ds_wreq), 32'd0);
    bus.m1_wdata = 32'h33;
    @(negedge clk);
    chk("wr_early_wreq3", 32'(bus.ds_wreq), 32'd0);
    bus.m1_wdata = 32'h99;
    wait_hi("wr_wreq", 7, 4);
    bus.m1_wvalid = 0;
    chk("wr_ds_addr", bus.ds_addr, 32'h0000_2000);
    chk("wr_ds_burst", 32'(bus.ds_burst), 32'd3);
    bus.ds_busy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_wdata", bus.ds_wdata, wexp[i]);
      bus.ds_wnext = 1;
    end
    @(negedge clk);
    chk("wr_drained", bus.ds_wdata, 32'd0);
    bus.ds_wnext = 0;
    bus.ds_busy = 0;
    wait_hi("wr_done", 3, 4);
    chk("wr_m0_quiet", 32'({bus.m0_done, bus.m0_err}), 32'd0);

    // contention out of reset
    reset = 1;
    @(negedge clk);
    reset = 0;
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_burst = 5'd1;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_burst = 5'd1;
    for (int k = 0; k < 4; k++) begin
      wait_hi((k % 2 == 0) ? "ct_gnt_m0" : "ct_gnt_m1", k % 2, 6);
      chk("ct_gnt_other", 32'((k % 2 == 0) ? bus.m1_gnt : bus.m0_gnt), 32'd0);
      serve_read(1, 32'hC0 + 32'(k));
      wait_hi((k % 2 == 0) ? "ct_done_m0" : "ct_done_m1", 2 + (k % 2), 6);
    end
    bus.m0_req = 0;
    bus.m1_req = 0;

    // word 14 + 2 words ends exactly at the line boundary and is legal
    @(negedge clk);
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h38; bus.m0_burst = 5'd2;
    wait_hi("bd_gnt", 0, 6);
    bus.m0_req = 0;
    serve_read(2, 32'hB0);
    wait_hi("bd_done", 2, 6);

    // illegal requests
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h38; bus.m0_burst = 5'd4;
    wait_hi("il_cross_err", 4, 6);
    chk("il_cross_no_done", 32'(bus.m0_done), 32'd0);
    bus.m0_addr = 32'h0; bus.m0_burst = 5'd0;
    @(negedge clk);
    wait_hi("il_zero_err", 4, 6);
    bus.m0_req = 0;
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h0; bus.m1_burst = 5'd17;
    wait_hi("il_big_err", 5, 6);
    bus.m1_req = 0;
    repeat (3) @(negedge clk);
    chk("il_no_ds_req", 32'(n_rreq + n_wreq), 32'd7);

    // timeout while ds_busy never rises
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_burst = 5'd1;
    wait_hi("to_gnt", 0, 6);
    bus.m0_req = 0;
    wait_hi("to_rreq", 6, 4);
    begin
      int k = 0;
      while ((bus.m0_err !== 1'b1) && (k < TIMEOUT + 5)) begin
        @(negedge clk);
        k++;
      end
      chk("to_cycles", 32'(k), 32'(TIMEOUT));
    end
    chk("to_no_done", 32'(bus.m0_done), 32'd0);

    // reset in the middle of an 8-beat read
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_burst = 5'd8;
    wait_hi("rs_gnt", 0, 6);
    bus.m0_req = 0;
    wait_hi("rs_rreq", 6, 4);
    bus.ds_busy = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.ds_rvalid = 1;
      bus.ds_rdata = 32'h70 + 32'(i);
    end
    @(negedge clk);
    reset = 1;
    bus.ds_rdata = 32'h55;
    @(negedge clk);
    #1;
    chk("rs_m0_out", 32'({bus.m0_gnt, bus.m0_rvalid, bus.m0_done, bus.m0_err}), 32'd0);
    chk("rs_m1_out", 32'({bus.m1_gnt, bus.m1_rvalid, bus.m1_done, bus.m1_err}), 32'd0);
    chk("rs_rdata", bus.m0_rdata | bus.m1_rdata, 32'd0);
    chk("rs_ds_req", 32'({bus.ds_rreq, bus.ds_wreq}), 32'd0);
    chk("rs_ds_addr", bus.ds_addr, 32'd0);
    chk("rs_ds_burst_wdata", 32'(bus.ds_burst) | bus.ds_wdata, 32'd0);
    reset = 0;
    bus.ds_rvalid = 0;
    bus.ds_busy = 0;
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_burst = 5'd1;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_burst = 5'd1;
    wait_hi("rs_next_gnt_m0", 0, 4);
    chk("rs_next_gnt_other", 32'(bus.m1_gnt), 32'd0);
    bus.m0_req = 0;
    bus.m1_req = 0;
    serve_read(1, 32'hD0);
    wait_hi("rs_next_done", 2, 6);
    repeat (3) @(negedge clk);

    chk("tot_done0", 32'(n_done0), 32'd5);
    chk("tot_done1", 32'(n_done1), 32'd3);
    chk("tot_err0", 32'(n_err0), 32'd3);
    chk("tot_err1", 32'(n_err1), 32'd1);
    chk("tot_rreq", 32'(n_rreq), 32'd9);
    chk("tot_wreq", 32'(n_wreq), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2_req_arbiter.md
L2_REQ_ARBITER -- requirements
Module: l2_req_arbiter

Interface
REQ-001 Parameter LINE_WORDS, default 16, words per cache line; also the maximum burst length.
REQ-002 Parameter TIMEOUT, default 255, cycles to wait for ds_busy to rise before the arbiter flags an error.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 mN_req  in  1  request from master N (N=0 I-side, N=1 D-side); held until mN_gnt.
REQ-006 mN_we  in  1  1=write burst, 0=read burst; sampled with mN_req.
REQ-007 mN_addr  in  32  word-aligned start byte address; bits[1:0] ignored.
REQ-008 mN_burst  in  5  burst length in words; legal range 1..16.
REQ-009 mN_wvalid / mN_wdata  in  1/32  write beat from master N; accepted only in state WFILL for the granted port.
REQ-010 mN_gnt  out  1  one-cycle pulse; request parameters are latched in that cycle.
REQ-011 mN_rvalid / mN_rdata  out  1/32  read beat returned to master N; mN_rdata is 0 whenever mN_rvalid is 0.
REQ-012 mN_done / mN_err  out  1/1  one-cycle completion pulse; mN_err pulses instead of mN_done on a rejected or timed-out burst.
REQ-013 ds_rreq / ds_wreq  out  1/1  one-cycle request pulse to the cache group.
REQ-014 ds_addr / ds_burst  out  32/5  latched address and length; held stable from the issue cycle until DONE.
REQ-015 ds_wdata  out  32  current write-buffer head; ds_wnext  in  1  downstream consumed one beat.
REQ-016 ds_rdata / ds_rvalid  in  32/1  read beat from downstream; ds_busy  in  1  downstream occupied.

Function
REQ-017 States: IDLE, WFILL, ISSUE, WAIT_BUSY, XFER, DONE.
REQ-018 IDLE: if any mN_req is high, grant exactly one port, pulse mN_gnt, and latch we, addr, and burst.
REQ-019 Arbitration is round-robin with a 1-bit last-grant pointer (reset value 1, so port 0 wins first). On simultaneous requests the port not granted last wins. The pointer updates only on a grant.
REQ-020 Legality check on the grant cycle: burst==0, burst>LINE_WORDS, or addr[5:2]+burst>LINE_WORDS (line crossing) -> DONE with err; no ds request is issued.
REQ-021 Legal write -> WFILL. Each cycle the granted port has mN_wvalid=1, the beat is pushed into the 16x32 write buffer. After burst beats -> ISSUE. Legal read -> ISSUE directly.
REQ-022 ISSUE: wait until ds_busy==0, then pulse ds_wreq (or ds_rreq) for exactly one cycle and go to WAIT_BUSY.
REQ-023 WAIT_BUSY: on ds_busy==1 -> XFER. If ds_busy stays low for TIMEOUT cycles -> DONE with err.
REQ-024 XFER read: forward each ds_rvalid beat to the granted port in the same cycle (combinational path, zero added latency), counting beats.
REQ-025 XFER write: ds_wdata shows the buffer head; each ds_wnext pops one entry.
REQ-026 XFER exit: go to DONE once beat count==burst and ds_busy==0. ds_rvalid or ds_wnext arriving after burst beats have been counted is ignored.
REQ-027 DONE: pulse mN_done or mN_err for one cycle -> IDLE. A new grant is possible in the next cycle, so the minimum issue-to-issue gap is 1 idle cycle.
REQ-028 The non-granted port's outputs stay 0 throughout; its mN_req may stay asserted without effect.
REQ-029 The beat counter is 5 bits and counts 0..16 without wrapping. The buffer read and write pointers are 4 bits and wrap modulo 16. The buffer is empty at the start of every write burst.
REQ-030 mN_wvalid outside WFILL is dropped silently.

Reset
REQ-031 On reset, state=IDLE, pointer=1, counters and buffer pointers=0.
REQ-032 On reset, all outputs =0: mN_gnt, mN_rvalid, mN_rdata, mN_done, mN_err, ds_rreq, ds_wreq, ds_addr, ds_burst, ds_wdata.
REQ-033 Reset mid-burst abandons the transaction: no done/err pulse is produced and buffered write data is discarded.

Structure
REQ-034 Shared package l2_pkg holds the state encoding, LINE_WORDS, the burst width (5), and the address field widths (tag 21, set 5, word 4, offset 2).
REQ-035 One sub-module, l2_wbuf: a 16x32 synchronous write buffer with push/pop/empty/count.
REQ-036 Expected RTL size: 200-300 lines total.

Verification
REQ-037 Read: m0 read addr 0x0000_1040, burst 4; downstream returns 4 beats 0xA0..0xA3 -> one ds_rreq pulse with ds_addr=0x1040, ds_burst=4; m0_rvalid x4 with the same data; then a single m0_done.
REQ-038 Write: m1 write addr 0x2000, burst 3, wdata 0x11/0x22/0x33 -> ds_wreq only after 3 beats are buffered; ds_wdata sequence 0x11, 0x22, 0x33 on successive ds_wnext; then m1_done.
REQ-039 Contention: m0 and m1 both request continuously out of reset -> grants alternate m0, m1, m0, m1; each grant is separated by a done.
REQ-040 Illegal request: addr word 14 with burst 4, then burst 0, then burst 17 -> m_err each time; ds_rreq and ds_wreq never pulse.
REQ-041 Timeout: ds_busy held at 0 after ds_rreq -> m_err exactly TIMEOUT cycles later; the FSM returns to IDLE.
REQ-042 Reset during XFER after 2 of 8 read beats -> all outputs 0 next cycle; no done pulse; the next request is granted to port 0.
